axil_regfile_wr: RTL and testbench

//  AXI4-lite write slave terminating the master side of the write CDC stage in the core clock domain.

---
 rtl/axil_defs.sv | 8 +
 rtl/axil_hold_reg.sv | 32 +++
 rtl/axil_regfile_wr.sv | 131 +++++++++++++
 tb/tb_axil_regfile_wr.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_defs.sv
// Shared AXI4-lite definitions for the CDC, interconnect and register blocks.
// Holds the B/R response encodings used by every AXI4-lite slave.
package axil_defs;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_hold_reg.sv
// Single-entry valid/ready holding register for one AXI4-lite channel.
// Ports: clk, rst_n (sync, active-low); in_data/in_valid/in_ready accept
// a beat; held/out_data expose it; pop releases it (may refill same edge).
module axil_hold_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             held,
    output logic [WIDTH-1:0] out_data,
    input  logic             pop
);

    // Ready while empty, or while the current entry leaves this edge.
    assign in_ready = rst_n && (!held || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held     <= 1'b0;
            out_data <= '0;
        end else if (in_valid && in_ready) begin
            held     <= 1'b1;
            out_data <= in_data;
        end else if (pop) begin
            held     <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_regfile_wr.sv
// AXI4-lite write slave into a bank of REG_COUNT control registers.
// Ports: clk, rst_n (sync, active-low); s_axil_aw*/w*/b* slave write
// channels; reg_out flat register contents; reg_wr per-register pulse.
module axil_regfile_wr
    import axil_defs::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 32,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                  REG_COUNT  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    output logic [REG_COUNT-1:0]            reg_wr
);

    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int W_W   = DATA_WIDTH + STRB_WIDTH;

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [W_W-1:0]        w_bundle;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      reg_idx;
    logic                  in_range;
    logic                  unused_awprot;

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    assign unused_awprot = ^s_axil_awprot;

    // B slot is free when empty or being drained this edge.
    assign commit = aw_held && w_held && (!s_axil_bvalid || s_axil_bready);

    axil_hold_reg #(
        .WIDTH (ADDR_WIDTH)
    ) u_aw_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (s_axil_awaddr),
        .in_valid (s_axil_awvalid),
        .in_ready (s_axil_awready),
        .held     (aw_held),
        .out_data (aw_addr),
        .pop      (commit)
    );

    axil_hold_reg #(
        .WIDTH (W_W)
    ) u_w_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({s_axil_wdata, s_axil_wstrb}),
        .in_valid (s_axil_wvalid),
        .in_ready (s_axil_wready),
        .held     (w_held),
        .out_data (w_bundle),
        .pop      (commit)
    );

    assign {w_data, w_strb} = w_bundle;

    // Modulo subtraction; addresses below BASE_ADDR wrap high and are
    // rejected by the explicit lower-bound compare as well.
    assign off      = aw_addr - BASE_ADDR;
    assign word_idx = off >> SHIFT;
    assign reg_idx  = word_idx[IDX_W-1:0];
    assign in_range = (aw_addr >= BASE_ADDR) &&
                      (word_idx < ADDR_WIDTH'(REG_COUNT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && in_range) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb[b]) begin
                    regs[reg_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_wr <= '0;
        end else if (commit && in_range) begin
            reg_wr <= REG_COUNT'(1) << reg_idx;
        end else begin
            reg_wr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= AXIL_RESP_OKAY;
        end else if (commit) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= in_range ? AXIL_RESP_OKAY
                                      : AXIL_RESP_SLVERR;
        end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_axil_regfile_wr.sv
// Directed self-checking bench for axil_regfile_wr.
// Drives inputs and samples outputs on the falling clock edge.
module tb_axil_regfile_wr;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [511:0] rout;
    logic [15:0]  rwr;

    logic [31:0]  x_awaddr;
    logic         x_awvalid;
    logic         x_awready;
    logic [31:0]  x_wdata;
    logic [3:0]   x_wstrb;
    logic         x_wvalid;
    logic         x_wready;
    logic [1:0]   x_bresp;
    logic         x_bvalid;
    logic [511:0] x_rout;
    logic [15:0]  x_rwr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] er [16];

    always #5 clk = ~clk;

    axil_regfile_wr dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (3'b000),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .reg_out        (rout),
        .reg_wr         (rwr)
    );

    axil_regfile_wr #(
        .BASE_ADDR (32'h0000_0100)
    ) dut_base (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (x_awaddr),
        .s_axil_awprot  (3'b101),
        .s_axil_awvalid (x_awvalid),
        .s_axil_awready (x_awready),
        .s_axil_wdata   (x_wdata),
        .s_axil_wstrb   (x_wstrb),
        .s_axil_wvalid  (x_wvalid),
        .s_axil_wready  (x_wready),
        .s_axil_bresp   (x_bresp),
        .s_axil_bvalid  (x_bvalid),
        .s_axil_bready  (1'b1),
        .reg_out        (x_rout),
        .reg_wr         (x_rwr)
    );

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack_exp();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = er[i];
        return v;
    endfunction

    // Same-cycle AW+W; returns at the falling edge after the commit edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        awaddr    = '0;
        awvalid   = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        wvalid    = 1'b0;
        bready    = 1'b1;
        x_awaddr  = '0;
        x_awvalid = 1'b0;
        x_wdata   = '0;
        x_wstrb   = '0;
        x_wvalid  = 1'b0;
        for (int i = 0; i < 16; i++) er[i] = '0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_regs", rout, 0);
        chk("rst_regwr", rwr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);

        // Same-cycle write to reg[1]
        wr(32'h4, 32'hDEAD_BEEF, 4'hF);
        er[1] = 32'hDEAD_BEEF;
        chk("t2_regs", rout, pack_exp());
        chk("t2_bvalid", bvalid, 1);
        chk("t2_bresp", bresp, 2'b00);
        chk("t2_regwr", rwr, 16'h0002);
        @(negedge clk);
        chk("t2_regwr_pulse", rwr, 0);
        chk("t2_bvalid_drop", bvalid, 0);

        // Seed reg[2] then W-before-AW byte1 write
        wr(32'h8, 32'h1122_3344, 4'hF);
        er[2] = 32'h1122_3344;
        chk("t3_seed_regwr", rwr, 16'h0004);
        @(negedge clk);
        wdata  = 32'h0000_AA00;
        wstrb  = 4'b0010;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        chk("t3_wready_held", wready, 0);
        chk("t3_awready_free", awready, 1);
        @(negedge clk);
        @(negedge clk);
        awaddr  = 32'h8;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        chk("t3_no_commit_yet", rout, pack_exp());
        @(negedge clk);
        er[2] = 32'h1122_AA44;
        chk("t3_regs", rout, pack_exp());
        chk("t3_bresp", bresp, 2'b00);
        chk("t3_regwr", rwr, 16'h0004);
        @(negedge clk);

        // Out of range
        wr(32'h40, 32'hFFFF_FFFF, 4'hF);
        chk("t4_bvalid", bvalid, 1);
        chk("t4_bresp", bresp, 2'b10);
        chk("t4_regs", rout, pack_exp());
        chk("t4_regwr", rwr, 0);
        @(negedge clk);

        // Below BASE_ADDR on the offset instance, then a legal write
        x_awaddr  = 32'hFC;
        x_wdata   = 32'h5555_5555;
        x_wstrb   = 4'hF;
        x_awvalid = 1'b1;
        x_wvalid  = 1'b1;
        @(negedge clk);
        x_awaddr  = 32'h104;
        @(negedge clk);
        x_awvalid = 1'b0;
        x_wvalid  = 1'b0;
        chk("t4b_bresp_low", x_bresp, 2'b10);
        chk("t4b_regwr_low", x_rwr, 0);
        chk("t4b_regs_low", x_rout, 0);
        @(negedge clk);
        chk("t4b_bresp_ok", x_bresp, 2'b00);
        chk("t4b_regwr_ok", x_rwr, 16'h0002);
        chk("t4b_regs_ok", x_rout, {448'h0, 32'h5555_5555, 32'h0});
        @(negedge clk);

        // Stalled B
        bready = 1'b0;
        wr(32'hC, 32'h0A0A_0A0A, 4'hF);
        er[3] = 32'h0A0A_0A0A;
        chk("t5_b1_valid", bvalid, 1);
        chk("t5_b1_resp", bresp, 2'b00);
        chk("t5_b1_regwr", rwr, 16'h0008);
        awaddr  = 32'h44;
        wdata   = 32'h1234_5678;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        chk("t5_awready_stall", awready, 0);
        chk("t5_wready_stall", wready, 0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_hold_valid", bvalid, 1);
        chk("t5_hold_resp", bresp, 2'b00);
        chk("t5_hold_awready", awready, 0);
        chk("t5_hold_regs", rout, pack_exp());
        bready = 1'b1;
        @(negedge clk);
        chk("t5_b2_valid", bvalid, 1);
        chk("t5_b2_resp", bresp, 2'b10);
        chk("t5_b2_regwr", rwr, 0);
        chk("t5_b2_awready", awready, 1);
        @(negedge clk);
        chk("t5_drain", bvalid, 0);

        // Back-to-back burst, one commit per cycle
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                chk($sformatf("t6_bvalid_%0d", i - 2), bvalid, 1);
                chk($sformatf("t6_bresp_%0d", i - 2), bresp, 2'b00);
                chk($sformatf("t6_regwr_%0d", i - 2), rwr,
                    16'(1 << (i - 2)));
            end
            if (i < 8) begin
                awaddr  = 32'(i * 4);
                wdata   = 32'hC0DE_0000 + 32'(i);
                wstrb   = 4'hF;
                awvalid = 1'b1;
                wvalid  = 1'b1;
            end else begin
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) er[i] = 32'hC0DE_0000 + 32'(i);
        chk("t6_regs", rout, pack_exp());
        chk("t6_drain", bvalid, 0);

        // Reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            awaddr  = 32'(32 + i * 4);
            wdata   = 32'hBAD0_0000 + 32'(i);
            awvalid = 1'b1;
            wvalid  = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) er[i] = '0;
        chk("t6r_bvalid", bvalid, 0);
        chk("t6r_regwr", rwr, 0);
        chk("t6r_awready", awready, 0);
        chk("t6r_regs", rout, pack_exp());
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6r_post_bvalid", bvalid, 0);
        chk("t6r_post_regwr", rwr, 0);
        chk("t6r_post_regs", rout, pack_exp());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
